bin2bcd_seq: RTL and testbench

- Sequential double-dabble converter: one binary value in, eight packed BCD digits out.
- Sits directly upstream of the 8-digit seven-segment scanner. Its bcd output drives the scanner's 32-bit digit word: digit k sits in bits [4k+3:4k], and digit 0 is the least significant.
- Converts one add-3/shift step per clock, so the combinational depth stays small at board clock rates.
- Holds the last result stable between conversions, so the display never shows intermediate values.

---
 rtl/bin2bcd_pkg.sv | 12 +
 rtl/dd_nibble_adj.sv | 13 +
 rtl/bin2bcd_seq.sv | 88 ++++++++
 tb/tb_bin2bcd_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [31:0] MAX_DEC     = 32'd99999999;
  localparam logic [31:0] SAT_PATTERN = 32'h99999999;

endpackage

// File: rtl/dd_nibble_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so the following left shift carries correctly into the next digit.
module dd_nibble_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// result held in bcd/ovf until the next completed conversion.
//
// state | meaning
// IDLE  | waiting for start; bcd/ovf hold the last result
// SHIFT | one adjust+shift per edge, WIDTH edges in total
module bin2bcd_seq #(
  parameter int unsigned WIDTH   = 27,
  parameter logic [31:0] MAX_DEC = bin2bcd_pkg::MAX_DEC
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bcd,
  output logic             ovf
);

  import bin2bcd_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] binreg;
  logic [31:0]      work;
  logic [31:0]      work_adj;
  logic [31:0]      shifted;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic [31:0]      bin_ext;

  assign bin_ext = 32'(bin);

  for (genvar i = 0; i < 8; i++) begin : g_adj
    dd_nibble_adj u_adj (
      .d (work[4*i +: 4]),
      .q (work_adj[4*i +: 4])
    );
  end

  // Top bit of the adjusted word falls off; it can only be set for values
  // beyond eight digits, which are replaced by the saturation pattern.
  assign shifted = 32'({work_adj, binreg[WIDTH-1]});

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      binreg <= '0;
      work   <= '0;
      count  <= '0;
      sat    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      bcd    <= '0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            binreg <= bin;
            work   <= '0;
            count  <= '0;
            sat    <= (bin_ext > MAX_DEC);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          work   <= shifted;
          binreg <= binreg << 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            bcd   <= sat ? SAT_PATTERN : shifted;
            ovf   <= sat;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: expected results are queued at each start
// and checked by a monitor whenever done pulses.
module tb_bin2bcd_seq;

  localparam int W = 27;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  bin = '0;
  logic          busy;
  logic          done;
  logic [31:0]   bcd;
  logic          ovf;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int accept_cyc = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [32:0] e;
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      total++;
      assert (exp_q.size() != 0)
        else begin bad++; $error("FAIL unexpected_done got=%0d want=>0 pending", exp_q.size()); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert ({bcd, ovf} === e)
          else begin
            bad++;
            $error("FAIL result got bcd=%h ovf=%b want bcd=%h ovf=%b", bcd, ovf, e[32:1], e[0]);
          end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want)
      else begin bad++; $error("FAIL %s got=%0h want=%0h", tag, got, want); end
  endtask

  // Call just after a falling edge; returns at the falling edge after the accepting edge.
  task automatic kick(input logic [W-1:0] v, input logic [31:0] eb, input logic eo, input bit push);
    bin   = v;
    start = 1'b1;
    if (push) exp_q.push_back({eb, eo});
    @(negedge clk);
    accept_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    chk("done_timeout", 64'(found), 64'd1);
    lat = cyc - accept_cyc;
  endtask

  initial begin
    int lat;
    int d0;
    int first_done;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd",  64'(bcd),  64'd0);
    chk("rst_ovf",  64'(ovf),  64'd0);
    clr = 1'b0;
    @(negedge clk);

    // zero input: latency and busy duration
    busy_cyc = 0;
    kick('0, 32'h00000000, 1'b0, 1);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(lat);
    chk("latency_zero", 64'(lat), 64'(W));
    chk("busy_cycles", 64'(busy_cyc), 64'(W));
    chk("busy_low_at_done", 64'(busy), 64'd0);

    @(negedge clk);
    kick(W'(12345678), 32'h12345678, 1'b0, 1);
    wait_done(lat);
    @(negedge clk);
    kick(W'(99999999), 32'h99999999, 1'b0, 1);
    wait_done(lat);
    @(negedge clk);
    kick(W'(100000000), 32'h99999999, 1'b1, 1);
    wait_done(lat);
    chk("ovf_sat", 64'(ovf), 64'd1);
    @(negedge clk);
    kick(W'(42), 32'h00000042, 1'b0, 1);
    wait_done(lat);
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // start while busy is ignored; output holds previous result mid-conversion
    @(negedge clk);
    d0 = done_cnt;
    kick(W'(255), 32'h00000255, 1'b0, 1);
    repeat (4) @(negedge clk);
    bin   = W'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_mid_conv", 64'(bcd), 64'h42);
    chk("busy_mid_conv", 64'(busy), 64'd1);
    wait_done(lat);
    chk("latency_255", 64'(lat), 64'(W));
    repeat (40) @(negedge clk);
    chk("single_done", 64'(done_cnt), 64'(d0 + 1));

    // abort by clr mid-conversion
    d0 = done_cnt;
    kick(W'(1000), 32'h0, 1'b0, 0);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("abort_bcd",  64'(bcd),  64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ovf",  64'(ovf),  64'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    kick(W'(9), 32'h00000009, 1'b0, 1);
    wait_done(lat);
    first_done = cyc;

    // start during the done cycle: accepted on the next edge, then W shift
    // edges, so done-to-done spans the accepting cycle plus W busy cycles
    kick(W'(31), 32'h00000031, 1'b0, 1);
    wait_done(lat);
    chk("b2b_latency", 64'(lat), 64'(W));
    chk("b2b_period", 64'(cyc - first_done), 64'(W + 1));
    chk("b2b_bcd", 64'(bcd), 64'h31);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
